hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall scheduler for the five-stage core. It sits beside decode and drives the PC, IF/ID and ID/EX pipeline-register enables. It inserts the single load-use bubble that the decode stage's memory-forwarding path relies on, flushes wrong-path instructions on taken branches and jumps, and freezes the pipe on data-memory busy. It also sequences the drain for SIIC (exception) and HALT, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles fetch is held after SIIC/HALT leaves decode (range 1–7)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  3  decode source reg 1 (Instruction[10:8])
- id_rt  in  3  decode source reg 2 (Instruction[7:5])
- id_rs_used  in  1  instruction reads id_rs
- id_rt_used  in  1  instruction reads id_rt
- id_siic  in  1  decode holds SIIC
- id_halt  in  1  decode holds HALT
- ex_memread  in  1  execute holds a load
- ex_regwrite  in  1  execute instruction writes a register
- ex_wreg  in  3  execute destination register
- ex_redirect  in  1  taken branch/jump resolved in execute
- mem_busy  in  1  data memory not ready
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID becomes NOP
- idex_bubble  out  1  ID/EX loaded with NOP
- pipe_freeze  out  1  all pipeline registers hold
- siic_go  out  1  one-cycle pulse: fetch may redirect to the handler
- halted  out  1  sticky halt indication
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- States: RUN, DRAIN, HALTED. A 3-bit drain counter and a kind flag (SIIC/HALT) are registered with the state.
- Default outputs in RUN with no event: pc_write=1, ifid_write=1, all other control outputs 0.
- Load-use hazard: ex_memread & ex_regwrite & id_valid & ((id_rs_used & id_rs==ex_wreg) | (id_rt_used & id_rt==ex_wreg)).
- RUN events, evaluated in strict priority order:
  - mem_busy: pipe_freeze=1, pc_write=0, ifid_write=0. State holds.
  - ex_redirect: ifid_flush=1, idex_bubble=1, pc_write=1. Any hazard, SIIC or HALT in decode is wrong-path and is ignored.
  - load-use: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble, because the hazard term clears once the bubble reaches execute.
  - id_valid & id_siic (or id_halt): the instruction passes to ID/EX with no bubble. Outputs pc_write=0, ifid_flush=1. Next state is DRAIN with counter=DRAIN_CYCLES-1 and kind=SIIC (or HALT). SIIC wins if both are set.
- DRAIN: pc_write=0 and ifid_flush=1 every cycle.
  - mem_busy freezes the counter and asserts pipe_freeze.
  - ex_redirect is ignored.
  - When counter==0 and mem_busy=0: kind SIIC → RUN with siic_go=1 that cycle; kind HALT → HALTED. Otherwise the counter decrements.
- HALTED: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. Only reset exits this state.
- stall_cnt increments on every cycle with pc_write=0 in RUN or DRAIN. It saturates at all-ones and does not count in HALTED.

## Timing
- Reset (rst=0, async): state=RUN, counter=0, stall_cnt=0, halted=0. With inputs idle, outputs are pc_write=1, ifid_write=1, all others 0.
- All control outputs are combinational from the registered state and the current inputs, so they take effect at the next clk rising edge. State, counter and stall_cnt update on that same edge.
- Load-use costs exactly 1 cycle. A taken branch costs 2 flushed slots, both applied in the same cycle.
- SIIC/HALT: fetch is held for exactly DRAIN_CYCLES+1 cycles in total (1 in RUN plus DRAIN_CYCLES in DRAIN), plus one extra per mem_busy cycle.
- Reset asserted mid-DRAIN returns to RUN immediately. No siic_go is issued.

## Test plan
- Load r3 in execute (ex_memread=1, ex_wreg=3); decode reads id_rs=3 with id_rs_used=1 → one cycle of pc_write=0 and idex_bubble=1, then normal flow; stall_cnt=1.
- Same hazard with ex_redirect=1 → ifid_flush=1, idex_bubble=1, pc_write=1; no stall; stall_cnt=0.
- id_siic=1, DRAIN_CYCLES=3 → pc_write low for 4 cycles; siic_go high in the 4th cycle only; state returns to RUN; stall_cnt=4.
- id_halt=1, with mem_busy=1 for 2 cycles during DRAIN → halted rises after 6 cycles and remains high; stall_cnt frozen at 6.
- Mid-DRAIN, assert rst=0 asynchronously → outputs return to reset values before the next edge; siic_go never pulses.
- Force 2^CNT_W+5 stall cycles with CNT_W=4 → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall scheduler for the five-stage core.
//   Inserts the single load-use bubble, flushes wrong-path work on a taken
//   branch/jump, freezes the pipe while data memory is busy, sequences the
//   SIIC/HALT drain and keeps a saturating stall-cycle counter.
// Ports:
//   clk, rst (async, active low)
//   id_*        : decode-stage instruction info
//   ex_*        : execute-stage load/write/redirect info
//   mem_busy    : data memory not ready
//   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze : pipe control
//   siic_go     : one-cycle pulse, fetch may redirect to the SIIC handler
//   halted      : sticky halt indication
//   stall_cnt   : saturating count of cycles with pc_write=0
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_siic,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [2:0]       ex_wreg,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             siic_go,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       kind_q, kind_d;   // 0: SIIC drain, 1: HALT drain
  logic       load_use;

  // Clears by itself once the bubble reaches execute, so at most one bubble.
  assign load_use = ex_memread & ex_regwrite & id_valid &
                    ((id_rs_used & (id_rs == ex_wreg)) |
                     (id_rt_used & (id_rt == ex_wreg)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    siic_go     = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
        end else if (ex_redirect) begin
          // Decode holds a wrong-path instruction: hazards/SIIC/HALT ignored.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid & (id_siic | id_halt)) begin
          // The SIIC/HALT itself moves on to ID/EX; younger fetches are killed.
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          state_d    = DRAIN;
          cnt_d      = DRAIN_INIT;
          kind_d     = ~id_siic;
        end
      end
      DRAIN: begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          ifid_write  = 1'b0;
        end else if (cnt_q == 3'd0) begin
          if (kind_q) begin
            state_d = HALTED;
          end else begin
            state_d = RUN;
            siic_go = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Halted cycles are not stalls and are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if ((state_q != HALTED) && !pc_write && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_rs_used, id_rt_used, id_siic, id_halt;
  logic [2:0] id_rs, id_rt, ex_wreg;
  logic       ex_memread, ex_regwrite, ex_redirect, mem_busy;

  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, siic_go, halted;
  logic [15:0] stall_cnt;
  logic       b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pipe_freeze, b_siic_go, b_halted;
  logic [3:0] b_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_siic(id_siic), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .siic_go(siic_go),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy for the saturation boundary.
  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_siic(id_siic), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .pipe_freeze(b_pipe_freeze), .siic_go(b_siic_go),
    .halted(b_halted), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_siic = 0; id_halt = 0; ex_memread = 0; ex_regwrite = 0; ex_wreg = 0;
    ex_redirect = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0; idle();
    @(negedge clk); rst = 1;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_r3();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 3'd3;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_ifid_write", 32'(ifid_write), 1);
    chk("rst_flush", 32'(ifid_flush), 0);
    chk("rst_bubble", 32'(idex_bubble), 0);
    chk("rst_freeze", 32'(pipe_freeze), 0);
    chk("rst_siic_go", 32'(siic_go), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk); rst = 1;

    // Load-use on rs
    cyc(); load_r3(); id_valid = 1; id_rs = 3; id_rs_used = 1; #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    chk("lu_flush", 32'(ifid_flush), 0);
    cyc(); ex_memread = 0; ex_regwrite = 0; #1;   // bubble now in execute
    chk("lu_after_pc_write", 32'(pc_write), 1);
    chk("lu_after_bubble", 32'(idex_bubble), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    // Match on rs but rs not read: no hazard
    cyc(); idle(); load_r3(); id_valid = 1; id_rs = 3; id_rt = 1; id_rt_used = 1; #1;
    chk("lu_unused_pc_write", 32'(pc_write), 1);
    // Match on rt
    cyc(); id_rt = 3; #1;
    chk("lu_rt_bubble", 32'(idex_bubble), 1);
    chk("lu_rt_pc_write", 32'(pc_write), 0);
    // Load without a register write: no hazard
    cyc(); ex_regwrite = 0; #1;
    chk("lu_norw_pc_write", 32'(pc_write), 1);
    chk("lu_rt_stall_cnt", 32'(stall_cnt), 2);

    // Hazard masked by a taken redirect
    do_reset();
    cyc(); load_r3(); id_valid = 1; id_rs = 3; id_rs_used = 1; ex_redirect = 1; #1;
    chk("br_flush", 32'(ifid_flush), 1);
    chk("br_bubble", 32'(idex_bubble), 1);
    chk("br_pc_write", 32'(pc_write), 1);
    // mem_busy outranks redirect
    cyc(); mem_busy = 1; #1;
    chk("busy_freeze", 32'(pipe_freeze), 1);
    chk("busy_pc_write", 32'(pc_write), 0);
    chk("busy_ifid_write", 32'(ifid_write), 0);
    chk("busy_flush", 32'(ifid_flush), 0);
    cyc(); idle(); #1;
    chk("br_stall_cnt", 32'(stall_cnt), 1);

    // SIIC drain: 4 cycles of pc_write=0, siic_go in the 4th only
    do_reset();
    cyc(); id_valid = 1; id_siic = 1; id_halt = 1; #1;   // SIIC wins over HALT
    chk("siic_c1_pc_write", 32'(pc_write), 0);
    chk("siic_c1_flush", 32'(ifid_flush), 1);
    chk("siic_c1_bubble", 32'(idex_bubble), 0);
    chk("siic_c1_go", 32'(siic_go), 0);
    cyc(); idle(); ex_redirect = 1; #1;                  // ignored in drain
    chk("siic_c2_pc_write", 32'(pc_write), 0);
    chk("siic_c2_go", 32'(siic_go), 0);
    cyc(); idle(); #1;
    chk("siic_c3_pc_write", 32'(pc_write), 0);
    chk("siic_c3_go", 32'(siic_go), 0);
    cyc(); #1;
    chk("siic_c4_pc_write", 32'(pc_write), 0);
    chk("siic_c4_go", 32'(siic_go), 1);
    cyc(); #1;
    chk("siic_c5_pc_write", 32'(pc_write), 1);
    chk("siic_c5_go", 32'(siic_go), 0);
    chk("siic_c5_halted", 32'(halted), 0);
    chk("siic_stall_cnt", 32'(stall_cnt), 4);

    // HALT with 2 busy cycles in drain: halted after 6 cycles
    do_reset();
    cyc(); id_valid = 1; id_halt = 1; #1;
    chk("halt_c1_pc_write", 32'(pc_write), 0);
    for (int c = 2; c <= 6; c++) begin
      cyc(); idle(); mem_busy = (c == 2 || c == 3); #1;
      chk($sformatf("halt_c%0d_pc_write", c), 32'(pc_write), 0);
      chk($sformatf("halt_c%0d_freeze", c), 32'(pipe_freeze), 32'(c == 2 || c == 3));
      chk($sformatf("halt_c%0d_halted", c), 32'(halted), 0);
    end
    for (int c = 7; c <= 9; c++) begin
      cyc(); idle(); if (c == 8) begin load_r3(); ex_redirect = 1; end #1;
      chk($sformatf("halt_c%0d_halted", c), 32'(halted), 1);
      chk($sformatf("halt_c%0d_pc_write", c), 32'(pc_write), 0);
      chk($sformatf("halt_c%0d_bubble", c), 32'(idex_bubble), 1);
      chk($sformatf("halt_c%0d_stall_cnt", c), 32'(stall_cnt), 6);
    end

    // Async reset in the middle of a SIIC drain
    do_reset();
    cyc(); id_valid = 1; id_siic = 1;
    cyc(); idle(); #1;
    chk("ar_pre_pc_write", 32'(pc_write), 0);
    #1; rst = 0; #1;                                     // well before the next rising edge
    chk("ar_pc_write", 32'(pc_write), 1);
    chk("ar_flush", 32'(ifid_flush), 0);
    chk("ar_siic_go", 32'(siic_go), 0);
    chk("ar_stall_cnt", 32'(stall_cnt), 0);
    cyc(); rst = 1;
    for (int c = 0; c < 5; c++) begin
      cyc(); #1;
      chk($sformatf("ar_post%0d_siic_go", c), 32'(siic_go), 0);
      chk($sformatf("ar_post%0d_pc_write", c), 32'(pc_write), 1);
    end

    // Counter saturation on the 4-bit copy
    do_reset();
    for (int c = 0; c < 15; c++) begin cyc(); mem_busy = 1; end
    cyc(); #1;
    chk("sat_at15_narrow", 32'(b_stall_cnt), 15);
    for (int c = 0; c < 5; c++) begin cyc(); mem_busy = 1; end
    cyc(); idle(); #1;                                   // 16 + 5 = 21 busy cycles
    chk("sat_narrow", 32'(b_stall_cnt), 15);
    chk("sat_wide", 32'(stall_cnt), 21);
    cyc(); #1;
    chk("sat_narrow_hold", 32'(b_stall_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
